// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcode constants, FSM state encoding, instruction-class
// codes and bus-mux select codes. Shared by control_decode, control_unit,
// the datapath and the testbench.
package control_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_NOT  = 4'd4,
    OP_RD   = 4'd5,
    OP_WR   = 4'd6,
    OP_BR   = 4'd7,
    OP_BRZ  = 4'd8,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_e;

  // Instruction classes: opcodes that share a micro-sequence share a class.
  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU, CLS_NOT, CLS_RD, CLS_WR,
    CLS_BR, CLS_BRZ, CLS_HALT, CLS_ILLEGAL
  } iclass_e;

  // Bus_1 mux: 0..3 select R0..R3, 4 selects PC.
  localparam logic [2:0] SEL1_PC   = 3'd4;
  // Bus_2 mux sources.
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational opcode -> instruction-class decode.
// Ports:
//   opcode_i  in  OP_SIZE  opcode field of the instruction register
//   iclass_o  out iclass_e instruction class; unlisted opcodes -> CLS_ILLEGAL
module control_decode
  import control_unit_pkg::*;
#(
  parameter int OP_SIZE = 4
) (
  input  logic [OP_SIZE-1:0] opcode_i,
  output iclass_e            iclass_o
);

  always_comb begin
    iclass_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_SIZE'(OP_NOP):  iclass_o = CLS_NOP;
      OP_SIZE'(OP_ADD),
      OP_SIZE'(OP_SUB),
      OP_SIZE'(OP_AND):  iclass_o = CLS_ALU;
      OP_SIZE'(OP_NOT):  iclass_o = CLS_NOT;
      OP_SIZE'(OP_RD):   iclass_o = CLS_RD;
      OP_SIZE'(OP_WR):   iclass_o = CLS_WR;
      OP_SIZE'(OP_BR):   iclass_o = CLS_BR;
      OP_SIZE'(OP_BRZ):  iclass_o = CLS_BRZ;
      OP_SIZE'(OP_HALT): iclass_o = CLS_HALT;
      default:           iclass_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the simple 4-register CPU.
// State is registered; control outputs are decoded combinationally from the
// state, the instruction register and the Z flag, so all outputs are 0 while
// rst is held (state forced to S_IDLE asynchronously).
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   instruction      IR contents: [WORD_SIZE-1 -: OP_SIZE] opcode,
//                    [3:2] src register, [1:0] dest register
//   zero             Z flag register output (BRZ condition)
//   Load_Reg[3:0]    one-hot R0..R3 load       Load_PC / Inc_PC  PC control
//   Load_IR          IR load                   Load_Add_R        address reg load
//   Load_Reg_Y/Z     ALU Y operand / Z flag load
//   Sel_Bus_1_Mux    0..3 = R0..R3, 4 = PC     Sel_Bus_2_Mux  0 ALU, 1 Bus_1, 2 mem
//   write            memory write strobe       halted  high in S_halt
//   illegal          illegal-opcode flag
// Configuration: define ILLEGAL_OP_TRAP_EN to halt on illegal opcodes with a
// sticky illegal flag; otherwise illegal opcodes run as NOP and illegal = 0.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 zero,
  output logic [3:0]           Load_Reg,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic [2:0]           Sel_Bus_1_Mux,
  output logic [1:0]           Sel_Bus_2_Mux,
  output logic                 write,
  output logic                 halted,
  output logic                 illegal
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [1:0] src, dest;
  logic [3:0] dest_onehot;

  assign src         = instruction[3:2];
  assign dest        = instruction[1:0];
  assign dest_onehot = 4'b0001 << dest;

  control_decode #(.OP_SIZE(OP_SIZE)) u_decode (
    .opcode_i (instruction[WORD_SIZE-1 -: OP_SIZE]),
    .iclass_o (iclass)
  );

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d     = illegal_q;
`endif
    Load_Reg      = '0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    write         = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;

      S_FET1: begin
        Sel_Bus_1_Mux = SEL1_PC;
        Sel_Bus_2_Mux = SEL2_BUS1;
        Load_Add_R    = 1'b1;
        state_d       = S_FET2;
      end

      S_FET2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = S_DEC;
      end

      S_DEC: begin
        case (iclass)
          CLS_NOP: state_d = S_FET1;
          CLS_ALU: begin
            Sel_Bus_1_Mux = {1'b0, src};
            Sel_Bus_2_Mux = SEL2_BUS1;
            Load_Reg_Y    = 1'b1;
            state_d       = S_EX1;
          end
          CLS_NOT: begin
            Sel_Bus_1_Mux = {1'b0, src};
            Sel_Bus_2_Mux = SEL2_ALU;
            Load_Reg_Z    = 1'b1;
            Load_Reg      = dest_onehot;
            state_d       = S_FET1;
          end
          CLS_RD, CLS_WR, CLS_BR, CLS_BRZ: begin
            if (iclass == CLS_BRZ && !zero) begin
              // Branch not taken: step the PC over the address byte.
              Inc_PC  = 1'b1;
              state_d = S_FET1;
            end else begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Add_R    = 1'b1;
              case (iclass)
                CLS_RD:  state_d = S_RD1;
                CLS_WR:  state_d = S_WR1;
                default: state_d = S_BR1;
              endcase
            end
          end
          CLS_HALT: state_d = S_HALT;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_FET1;
`endif
          end
        endcase
      end

      S_EX1: begin
        Sel_Bus_1_Mux = {1'b0, dest};
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_Reg_Z    = 1'b1;
        Load_Reg      = dest_onehot;
        state_d       = S_FET1;
      end

      S_RD1, S_WR1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_d       = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end

      S_RD2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Reg      = dest_onehot;
        state_d       = S_FET1;
      end

      S_WR2: begin
        Sel_Bus_1_Mux = {1'b0, src};
        write         = 1'b1;
        state_d       = S_FET1;
      end

      S_BR1: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        state_d       = S_BR2;
      end

      S_BR2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        state_d       = S_FET1;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import control_unit_pkg::*;

  typedef struct packed {
    logic [3:0] ld_reg;
    logic       ld_pc, inc_pc, ld_ir, ld_ar, ld_y, ld_z;
    logic [2:0] s1;
    logic [1:0] s2;
    logic       wr, halted, ill;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instruction;
  logic       zero_in;
  logic [3:0] Load_Reg;
  logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       write, halted, illegal;

  control_unit #(.WORD_SIZE(8), .OP_SIZE(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero_in),
    .Load_Reg(Load_Reg), .Load_PC(Load_PC), .Inc_PC(Inc_PC), .Load_IR(Load_IR),
    .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .write(write), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  ov_t obs;
  always_comb obs = {Load_Reg, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y,
                     Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted, illegal};

  int  n_tests = 0;
  int  n_fail  = 0;
  ov_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input ov_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    n_tests++;
    assert ((Load_PC & Inc_PC) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_pc_excl observed Load_PC=%b Inc_PC=%b expected not both 1",
             tag, Load_PC, Inc_PC);
    end
    n_tests++;
    assert ($countones(Load_Reg) <= 1) else begin
      n_fail++;
      $error("FAIL %s_onehot observed Load_Reg=%b expected popcount<=1", tag, Load_Reg);
    end
  endtask

  // Reference: the bus transactions each instruction performs, one entry per cycle.
  function automatic ov_t v_none();
    return '0;
  endfunction

  function automatic ov_t v_addr_from_pc();
    ov_t v = '0;
    v.s1 = 3'd4; v.s2 = 2'd1; v.ld_ar = 1'b1;
    return v;
  endfunction

  function automatic ov_t v_halted(input logic ill);
    ov_t v = '0;
    v.halted = 1'b1; v.ill = ill;
    return v;
  endfunction

  task automatic build(input logic [7:0] ins, input logic z);
    ov_t v;
    int op = int'(ins[7:4]);
    logic [1:0] src = ins[3:2];
    logic [1:0] dst = ins[1:0];
    exp_q.delete();
    exp_q.push_back(v_addr_from_pc());                      // fetch: MAR <- PC
    v = '0; v.s2 = 2'd2; v.ld_ir = 1'b1; v.inc_pc = 1'b1;   // IR <- mem, PC++
    exp_q.push_back(v);
    case (op)
      1, 2, 3: begin
        v = '0; v.s1 = {1'b0, src}; v.s2 = 2'd1; v.ld_y = 1'b1;
        exp_q.push_back(v);
        v = '0; v.s1 = {1'b0, dst}; v.s2 = 2'd0; v.ld_z = 1'b1; v.ld_reg = 4'b0001 << dst;
        exp_q.push_back(v);
      end
      4: begin
        v = '0; v.s1 = {1'b0, src}; v.s2 = 2'd0; v.ld_z = 1'b1; v.ld_reg = 4'b0001 << dst;
        exp_q.push_back(v);
      end
      5, 6, 7: begin
        exp_q.push_back(v_addr_from_pc());
        v = '0; v.s2 = 2'd2; v.ld_ar = 1'b1; v.inc_pc = (op != 7);
        exp_q.push_back(v);
        v = '0;
        if (op == 5) begin v.s2 = 2'd2; v.ld_reg = 4'b0001 << dst; end
        if (op == 6) begin v.s1 = {1'b0, src}; v.wr = 1'b1; end
        if (op == 7) begin v.s2 = 2'd2; v.ld_pc = 1'b1; end
        exp_q.push_back(v);
      end
      8: begin
        if (z) begin
          exp_q.push_back(v_addr_from_pc());
          v = '0; v.s2 = 2'd2; v.ld_ar = 1'b1; exp_q.push_back(v);
          v = '0; v.s2 = 2'd2; v.ld_pc = 1'b1; exp_q.push_back(v);
        end else begin
          v = '0; v.inc_pc = 1'b1; exp_q.push_back(v);
        end
      end
      default: exp_q.push_back(v_none());                  // NOP, HALT, illegal decode cycle
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [7:0] ins, input logic z);
    instruction = ins;
    zero_in     = z;
    build(ins, z);
    foreach (exp_q[i]) begin
      check($sformatf("%s_c%0d", tag, i), exp_q[i]);
      tick();
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_asserted"}, v_none());
    tick();
    rst = 1'b0;
    check({tag, "_idle"}, v_none());
    tick();
  endtask

  initial begin
    logic [7:0] rnd;
    int         op;

    rst = 1'b1; instruction = 8'h00; zero_in = 1'b0;
    tick(); tick();
    check("reset_state", v_none());
    rst = 1'b0;
    check("idle_after_release", v_none());
    tick();

    // Directed instruction sequences
    run_instr("add_r1_r2", 8'h16, 1'b0);
    run_instr("brz_not_taken", 8'h80, 1'b0);
    run_instr("brz_taken", 8'h80, 1'b1);
    run_instr("wr_src0", 8'h62, 1'b0);
    run_instr("not_r3", 8'h4F, 1'b1);
    run_instr("rd_r2", 8'h52, 1'b0);

    // Random legal instructions (illegal ones too when they behave as NOP)
    for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_OP_TRAP_EN
      op = int'($urandom_range(0, 8));
`else
      op = int'($urandom_range(0, 14));
`endif
      rnd = 8'($urandom());
      run_instr($sformatf("rand%0d_op%0d", n, op), {op[3:0], rnd[3:0]}, rnd[4]);
    end
    check("latency_end", v_addr_from_pc());

    // Reset asserted in the middle of S_rd1
    instruction = 8'h53; zero_in = 1'b0;
    build(8'h53, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_pre_rst_c%0d", i), exp_q[i]);
      if (i < 3) tick();
    end
    #2 rst = 1'b1;
    #1 check("rst_mid_rd1", v_none());
    tick(); tick();
    rst = 1'b0;
    check("rst_release_idle", v_none());
    tick();
    check("first_fet1_after_rst", v_addr_from_pc());

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 8));
      rnd = 8'($urandom());
      run_instr($sformatf("rand_b%0d_op%0d", n, op), {op[3:0], rnd[3:0]}, rnd[5]);
    end

    // HALT holds until reset
    run_instr("halt", 8'hF0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_hold%0d", i), v_halted(1'b0));
      tick();
    end
    reset_pulse("halt_rst");

    // Illegal opcode 9
`ifdef ILLEGAL_OP_TRAP_EN
    run_instr("illegal_trap", 8'h90, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("illegal_hold%0d", i), v_halted(1'b1));
      tick();
    end
    reset_pulse("illegal_rst");
    check("illegal_cleared_fet1", v_addr_from_pc());
`else
    run_instr("illegal_nop", 8'h90, 1'b0);
    check("illegal_nop_fet1", v_addr_from_pc());
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 8, instruction width.
REQ-002 SHALL provide parameter OP_SIZE, default 4, opcode field width, taken from instruction[WORD_SIZE-1 -: OP_SIZE].
REQ-003 SHALL provide ports, one per line:
  clk  in  1  system clock, rising edge
  rst  in  1  asynchronous, active-high reset
  instruction  in  WORD_SIZE  IR contents; [3:2] = src, [1:0] = dest
  zero  in  1  Z flag register output
  Load_Reg  out  4  one-hot load enable for R0..R3
  Load_PC  out  1  PC parallel load
  Inc_PC  out  1  PC increment
  Load_IR  out  1  IR load
  Load_Add_R  out  1  address register load
  Load_Reg_Y  out  1  ALU operand-Y register load
  Load_Reg_Z  out  1  Z flag register load
  Sel_Bus_1_Mux  out  3  0..3 = R0..R3, 4 = PC
  Sel_Bus_2_Mux  out  2  0 = ALU, 1 = Bus_1, 2 = memory
  write  out  1  memory write strobe
  halted  out  1  high in S_halt
  illegal  out  1  illegal-opcode flag

Function
REQ-004 SHALL be a Moore/Mealy FSM: state registered; outputs combinational from state and instruction; every output not listed for a state = 0.
REQ-005 SHALL decode opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=15; 9..14 illegal.
REQ-006 S_idle: no outputs; -> S_fet1.
REQ-007 S_fet1: Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R; -> S_fet2.
REQ-008 S_fet2: Sel_Bus_2_Mux=2, Load_IR, Inc_PC; -> S_dec.
REQ-009 S_dec NOP: -> S_fet1. ADD/SUB/AND: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=1, Load_Reg_Y; -> S_ex1.
REQ-010 S_dec NOT: Sel_Bus_1_Mux=src, Sel_Bus_2_Mux=0, Load_Reg_Z, Load_Reg[dest]; -> S_fet1.
REQ-011 S_dec RD/WR/BR, and BRZ with zero=1: Sel_Bus_1_Mux=4, Sel_Bus_2_Mux=1, Load_Add_R; -> S_rd1/S_wr1/S_br1.
REQ-012 S_dec BRZ with zero=0: Inc_PC only (skip address byte); -> S_fet1.
REQ-013 S_dec HALT: -> S_halt. Illegal opcode: per REQ-021/022.
REQ-014 S_ex1: Sel_Bus_1_Mux=dest, Sel_Bus_2_Mux=0, Load_Reg_Z, Load_Reg[dest]; -> S_fet1.
REQ-015 S_rd1 / S_wr1: Sel_Bus_2_Mux=2, Load_Add_R, Inc_PC; -> S_rd2 / S_wr2. S_rd2: Sel_Bus_2_Mux=2, Load_Reg[dest]. S_wr2: Sel_Bus_1_Mux=src, write. Both -> S_fet1.
REQ-016 S_br1: Sel_Bus_2_Mux=2, Load_Add_R; -> S_br2. S_br2: Sel_Bus_2_Mux=2, Load_PC; -> S_fet1.
REQ-017 S_halt: all outputs 0 except halted=1 (and illegal per REQ-021); exits only via rst.
REQ-018 Load_PC and Inc_PC SHALL never be asserted in the same cycle; Load_Reg SHALL be zero or one-hot.
REQ-019 Latency from S_fet1 entry to next S_fet1: NOP 3, NOT 3, BRZ not-taken 3, ADD/SUB/AND 4, RD/WR/BR/BRZ taken 5 cycles.

Reset
REQ-020 rst=1 SHALL force S_idle immediately, mid-instruction included; all outputs 0, halted=0, illegal=0; first S_fet1 one cycle after rst release.

Configuration
REQ-021 With ILLEGAL_OP_TRAP_EN defined: illegal opcode in S_dec -> S_halt; illegal=1 sticky until rst.
REQ-022 Without ILLEGAL_OP_TRAP_EN: illegal opcode executes as NOP; illegal tied 0.

Structure
REQ-023 Shared package SHALL hold opcode constants, state encoding and Sel_Bus_1/Sel_Bus_2 select codes, reused by datapath and bench.
REQ-024 One sub-module SHALL be natural: control_decode (combinational opcode -> instruction-class decode); FSM in control_unit.

Verification
REQ-025 rst pulse mid-S_rd1 -> S_idle same cycle, all outputs 0; S_fet1 one cycle after release.
REQ-026 instruction=8'h16 (ADD R1,R2) -> Load_Reg_Y with Sel_Bus_1_Mux=1 in S_dec; Load_Reg=4'b0100, Sel_Bus_1_Mux=2 in S_ex1; 4 cycles total.
REQ-027 instruction=8'h80, zero=0 -> single Inc_PC in S_dec, no Load_PC, back to S_fet1 in 3 cycles; zero=1 -> Load_PC in S_br2 after 5 cycles.
REQ-028 instruction=8'h62 (WR src=0) -> two Inc_PC pulses (fet2, wr1), write=1 with Sel_Bus_1_Mux=0 in S_wr2.
REQ-029 instruction=8'hF0 -> halted=1 held for 20 cycles; instruction=8'h90 -> halted=1, illegal=1 with ILLEGAL_OP_TRAP_EN, NOP timing without.
REQ-030 All runs: assertion Load_PC&Inc_PC never 1; Load_Reg popcount <= 1.
